// File: rtl/mc_control.sv
// mc_control: multicycle CPU control FSM (Moore decode, FETCH pc/ir writes gated by memReady); define CU_ADDI_EN to enable opcode 1000 add-immediate states
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       memReady,
    output logic [1:0] aoi,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IMMEX  = 4'd10,
        IMMWB  = 4'd11
    } state_t;

    state_t cur;

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else begin
            case (cur)
                FETCH:  cur <= memReady ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        4'b0000:          cur <= EXEC;
                        4'b0100, 4'b0101: cur <= MEMADR;
                        4'b0110:          cur <= BRANCH;
                        4'b0111:          cur <= JUMP;
`ifdef CU_ADDI_EN
                        4'b1000:          cur <= IMMEX;
`endif
                        default:          cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= (opcode == 4'b0100) ? MEMRD : MEMWR;
                MEMRD:  cur <= memReady ? MEMWB : MEMRD;
                MEMWR:  cur <= memReady ? FETCH : MEMWR;
                EXEC:   cur <= ALUWB;
                IMMEX:  cur <= IMMWB;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        state       = cur;
        memRead     = (cur == FETCH) || (cur == MEMRD);
        irWrite     = (cur == FETCH) && memReady;
        pcWrite     = ((cur == FETCH) && memReady) || (cur == JUMP);
        pcWriteCond = cur == BRANCH;
        iorD        = (cur == MEMRD) || (cur == MEMWR);
        memWrite    = cur == MEMWR;
        memToReg    = cur == MEMWB;
        regDst      = cur == ALUWB;
        regWrite    = (cur == MEMWB) || (cur == ALUWB) || (cur == IMMWB);
        aluSrcA     = (cur == MEMADR) || (cur == EXEC) || (cur == BRANCH) || (cur == IMMEX);
        aluSrcB     = (cur == FETCH) ? 2'b01 :
                      (cur == DECODE) ? 2'b11 :
                      ((cur == MEMADR) || (cur == IMMEX)) ? 2'b10 : 2'b00;
        aoi         = (cur == EXEC) ? 2'b10 : (cur == BRANCH) ? 2'b01 : 2'b00;
        pcSource    = (cur == BRANCH) ? 2'b01 : (cur == JUMP) ? 2'b10 : 2'b00;
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for mc_control with a per-cycle table-driven reference model
module tb_mc_control;
    logic       clk = 0;
    logic       reset = 1;
    logic [3:0] opcode = 4'b0000;
    logic       memReady = 1;
    logic [1:0] aoi, aluSrcB, pcSource;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int m_state = 0;
    bit armed = 0;
    logic [15:0] tbl [12];

    mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .aoi(aoi), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource), .state(state)
    );

    always #5 clk = ~clk;

    // vector: aoi, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource
    function automatic logic [15:0] outs();
        return {aoi, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource};
    endfunction

    function automatic int model_next(int s, logic [3:0] op, logic rdy, logic rst);
        if (rst) return 0;
        if (s == 0) return rdy ? 1 : 0;
        if (s == 1) begin
            if (op == 4'b0000) return 6;
            if (op == 4'b0100 || op == 4'b0101) return 2;
            if (op == 4'b0110) return 8;
            if (op == 4'b0111) return 9;
`ifdef CU_ADDI_EN
            if (op == 4'b1000) return 10;
`endif
            return 0;
        end
        if (s == 2) return (op == 4'b0100) ? 3 : 5;
        if (s == 3) return rdy ? 4 : 3;
        if (s == 5) return rdy ? 0 : 5;
        if (s == 6) return 7;
        if (s == 10) return 11;
        return 0;
    endfunction

    always @(posedge clk) m_state <= model_next(m_state, opcode, memReady, reset);

    always @(negedge clk) begin
        if (armed) begin
            logic [15:0] exp;
            exp = tbl[m_state];
            if (m_state == 0 && !memReady) begin
                exp[13] = 1'b0;
                exp[8]  = 1'b0;
            end
            checks++;
            if (state !== m_state[3:0] || outs() !== exp || (memRead && memWrite)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t state=%0d outs=%b expected state=%0d outs=%b",
                         $time, state, outs(), m_state, exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic seq(string name, int exp []);
        foreach (exp[i]) begin
            step();
            chk(name, int'(state), exp[i]);
        end
    endtask

    initial begin
        tbl[0]  = 16'b00_1_0_0_1_0_1_0_0_0_0_01_00;
        tbl[1]  = 16'b00_0_0_0_0_0_0_0_0_0_0_11_00;
        tbl[2]  = 16'b00_0_0_0_0_0_0_0_0_0_1_10_00;
        tbl[3]  = 16'b00_0_0_1_1_0_0_0_0_0_0_00_00;
        tbl[4]  = 16'b00_0_0_0_0_0_0_1_0_1_0_00_00;
        tbl[5]  = 16'b00_0_0_1_0_1_0_0_0_0_0_00_00;
        tbl[6]  = 16'b10_0_0_0_0_0_0_0_0_0_1_00_00;
        tbl[7]  = 16'b00_0_0_0_0_0_0_0_1_1_0_00_00;
        tbl[8]  = 16'b01_0_1_0_0_0_0_0_0_0_1_00_01;
        tbl[9]  = 16'b00_1_0_0_0_0_0_0_0_0_0_00_10;
        tbl[10] = 16'b00_0_0_0_0_0_0_0_0_0_1_10_00;
        tbl[11] = 16'b00_0_0_0_0_0_0_0_0_1_0_00_00;

        step();
        armed = 1;
        chk("reset_state", int'(state), 0);
        chk("reset_memRead", int'(memRead), 1);
        chk("reset_irWrite", int'(irWrite), 1);
        chk("reset_pcWrite", int'(pcWrite), 1);
        chk("reset_aoi", int'(aoi), 0);
        reset = 0;

        opcode = 4'b0000;
        seq("rtype_seq", '{1, 6});
        chk("rtype_aoi", int'(aoi), 2);
        seq("rtype_seq", '{7});
        chk("rtype_regWrite", int'(regWrite), 1);
        chk("rtype_regDst", int'(regDst), 1);
        seq("rtype_seq", '{0});

        opcode = 4'b0100;
        seq("load_seq", '{1, 2, 3});
        memReady = 0;
        opcode = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            seq("load_wait", '{3});
            chk("load_memRead", int'(memRead), 1);
            chk("load_iorD", int'(iorD), 1);
        end
        memReady = 1;
        seq("load_seq", '{4, 0});

        opcode = 4'b0110;
        seq("branch_seq", '{1, 8});
        chk("branch_aoi", int'(aoi), 1);
        chk("branch_pcWriteCond", int'(pcWriteCond), 1);
        seq("branch_seq", '{0});

        opcode = 4'b1111;
        seq("illegal_seq", '{1, 0});
        chk("illegal_regWrite", int'(regWrite), 0);
        chk("illegal_memWrite", int'(memWrite), 0);

        opcode = 4'b0111;
        seq("jump_seq", '{1, 9});
        chk("jump_pcSource", int'(pcSource), 2);
        seq("jump_seq", '{0});

        memReady = 0;
        seq("fetch_hold", '{0, 0});
        chk("fetch_hold_pcWrite", int'(pcWrite), 0);
        chk("fetch_hold_irWrite", int'(irWrite), 0);
        memReady = 1;

        opcode = 4'b0101;
        seq("store_seq", '{1, 2, 5});
        memReady = 0;
        seq("store_wait", '{5});
        chk("store_memWrite", int'(memWrite), 1);
        reset = 1;
        seq("store_reset", '{0});
        chk("store_reset_memWrite", int'(memWrite), 0);
        reset = 0;
        memReady = 1;
        seq("store2_seq", '{1, 2, 5, 0});

        opcode = 4'b1000;
`ifdef CU_ADDI_EN
        seq("addi_seq", '{1, 10, 11});
        chk("addi_regWrite", int'(regWrite), 1);
        seq("addi_seq", '{0});
`else
        seq("addi_off_seq", '{1, 0});
`endif
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
